dprintf_uart_tx: RTL and testbench
==================================

Name: dprintf_uart_tx

Overview:
- Consumer end of the dprintf_byte interface: captures the per-cycle byte stream produced by the dprintf formatter.
- Buffers captured bytes in a FIFO and serialises them over an 8N1 UART transmit line.
- Inserts an escaped address header whenever the byte address is not consecutive, so a host can rebuild the screen/buffer image.
- Sits after dprintf in place of a display, for debug output on boards without a character display.

Parameters:
- FIFO_LOG2, 4, log2 of FIFO depth (depth 16 entries of {address[15:0], data[7:0]}).
- CLKS_PER_BIT, 868, clock cycles per UART bit; legal range 2..65535.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- dprintf_byte__valid  input  1  byte present this cycle; no backpressure.
- dprintf_byte__data  input  8  character byte.
- dprintf_byte__address  input  16  destination address of the byte.
- clear_overflow  input  1  synchronous clear of overflow and drop_count.
- txd  output  1  UART serial output, idle high.
- busy  output  1  high when FIFO is non-empty, sequencer is not IDLE, or shifter is active.
- overflow  output  1  sticky: a byte was dropped.
- drop_count  output  8  dropped bytes, saturating at 0xFF.

Behaviour:
- Reset values: txd=1, busy=0, overflow=0, drop_count=0, FIFO empty, sequencer IDLE, last_addr_valid=0, last_addr=0.
- FIFO write:
  - Every cycle with valid=1 writes one entry unless full; fullness is evaluated on the registered count before any same-cycle pop.
  - Push while full: the byte is dropped, overflow is set, drop_count increments (saturating), and last_addr_valid is cleared so the next byte carries a header.
  - clear_overflow has priority over a same-cycle increment: result is overflow=0, drop_count=0.
- Sequencer states: IDLE, ESC_A, MARK, ADDR_HI, ADDR_LO, ESC_D, DATA. Each non-IDLE state loads exactly one byte into the shifter when the shifter is idle, then advances.
  - IDLE: if the FIFO is non-empty, pop the head into a holding register. If !last_addr_valid or address != last_addr+1 (mod 2^16; 0xFFFF->0x0000 is consecutive), go to ESC_A. Otherwise, if data==0x1B go to ESC_D, else go to DATA.
  - ESC_A sends 0x1B -> MARK sends 0x40 -> ADDR_HI sends address[15:8] -> ADDR_LO sends address[7:0].
  - After ADDR_LO: go to ESC_D if data==0x1B, else DATA. Header address bytes are never escaped.
  - ESC_D sends 0x1B -> DATA.
  - DATA sends data; updates last_addr=address and last_addr_valid=1; returns to IDLE.
- Host decode rules: 0x1B 0x1B is a literal 0x1B; 0x1B 0x40 hi lo sets the address; any other byte is data at current address, after which the address increments.
- Shifter:
  - Frame is 10 bits: start=0, data LSB first, stop=1. Each bit is held for exactly CLKS_PER_BIT cycles.
  - A new byte may load in the cycle after the stop bit completes, so back-to-back frames have no idle gap.
- Latency: a byte with valid=1 in cycle 0 into an empty, idle block (header not needed) drives the start bit on txd from cycle 2.
- Reset mid-frame: txd returns to 1 immediately; the FIFO and all state are discarded.
- Throughput: the FIFO absorbs bursts; sustained input faster than one byte per 10*CLKS_PER_BIT cycles overflows by design.

Test Plan:
- Single byte, CLKS_PER_BIT=4: addr 0x1010, data 0x41 -> txd frames 0x1B, 0x40, 0x10, 0x10, 0x41 (bits LSB first), 200 cycles total; start bit of the first frame at cycle 2; busy falls after the last stop bit.
- Consecutive run: addrs 0x2010, 0x2011, 0x2012 with data 0x31, 0x32, 0x33 -> one header, then 0x31, 0x32, 0x33 with no gaps. Next byte at 0x2020 -> new header 0x1B 0x40 0x20 0x20.
- Escape: data 0x1B at addr 0x3011 following 0x3010 -> frames 0x1B 0x1B only. Header addr 0x1B1B -> 0x1B 0x40 0x1B 0x1B, then data, with no extra escapes.
- Wrap: addr 0xFFFF then 0x0000 -> no header before the second byte.
- Overflow, FIFO_LOG2=4: 20 consecutive valid cycles -> 16 stored (one popped early, so 17 accepted), drop_count=3, overflow=1. The next accepted byte carries a header. clear_overflow -> overflow=0, drop_count=0.
- Reset asserted mid-data-bit -> txd=1 in the same cycle, busy=0. After release, the first byte sends a full header.

Source files
------------

// File: rtl/dprintf_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : dprintf_uart_tx
// Function : Captures the dprintf byte stream into a FIFO and sends it as 8N1
//            UART frames, with an escaped address header on address jumps.
// Revision : 1.0 - initial release
// ============================================================================
module dprintf_uart_tx #(
    parameter int FIFO_LOG2    = 4,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dprintf_byte__valid,
    input  logic [7:0]  dprintf_byte__data,
    input  logic [15:0] dprintf_byte__address,
    input  logic        clear_overflow,
    output logic        txd,
    output logic        busy,
    output logic        overflow,
    output logic [7:0]  drop_count
);

    localparam int                   c_DEPTH_N  = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2:0]   c_DEPTH    = {1'b1, {FIFO_LOG2{1'b0}}};
    localparam logic [FIFO_LOG2:0]   c_CNT_ONE  = (FIFO_LOG2 + 1)'(1);
    localparam logic [FIFO_LOG2-1:0] c_PTR_ONE  = FIFO_LOG2'(1);
    localparam logic [15:0]          c_BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]           c_STOP_IDX = 4'd9;
    localparam logic [7:0]           c_ESC      = 8'h1B;
    localparam logic [7:0]           c_MARK     = 8'h40;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_ESC_A   = 3'd1;
    localparam logic [2:0] c_ST_MARK    = 3'd2;
    localparam logic [2:0] c_ST_ADDR_HI = 3'd3;
    localparam logic [2:0] c_ST_ADDR_LO = 3'd4;
    localparam logic [2:0] c_ST_ESC_D   = 3'd5;
    localparam logic [2:0] c_ST_DATA    = 3'd6;

    // FIFO entries are {address[15:0], data[7:0]}
    logic [23:0]          r_mem [0:c_DEPTH_N-1];
    logic [FIFO_LOG2-1:0] r_wr_ptr;
    logic [FIFO_LOG2-1:0] r_rd_ptr;
    logic [FIFO_LOG2:0]   r_count;
    logic                 r_overflow;
    logic [7:0]           r_drop_count;

    logic [2:0]  r_state;
    logic [15:0] r_hold_addr;
    logic [7:0]  r_hold_data;
    logic [15:0] r_last_addr;
    logic        r_last_valid;

    logic        r_txd;
    logic        r_sh_busy;
    logic [8:0]  r_sh_data;
    logic [3:0]  r_bit_idx;
    logic [15:0] r_clk_cnt;

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_drop;
    logic        w_pop;
    logic [15:0] w_head_addr;
    logic [7:0]  w_head_data;
    logic [15:0] w_next_addr;
    logic        w_consec;
    logic        w_bit_end;
    logic        w_sh_ready;
    logic        w_load;
    logic [7:0]  w_load_byte;
    logic [2:0]  w_state_next;

    // Fullness uses the registered count, so a same-cycle pop never frees a slot.
    assign w_full      = (r_count == c_DEPTH);
    assign w_empty     = (r_count == '0);
    assign w_push      = dprintf_byte__valid && !w_full;
    assign w_drop      = dprintf_byte__valid && w_full;
    assign w_head_addr = r_mem[r_rd_ptr][23:8];
    assign w_head_data = r_mem[r_rd_ptr][7:0];
    assign w_next_addr = r_last_addr + 16'd1;
    assign w_consec    = r_last_valid && (w_head_addr == w_next_addr);

    // The shifter can take a new byte on the final cycle of a stop bit.
    assign w_bit_end  = (r_clk_cnt == c_BIT_LAST);
    assign w_sh_ready = !r_sh_busy || (w_bit_end && (r_bit_idx == c_STOP_IDX));
    assign w_load     = (r_state != c_ST_IDLE) && w_sh_ready;

    assign txd        = r_txd;
    assign busy       = !w_empty || (r_state != c_ST_IDLE) || r_sh_busy;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {dprintf_byte__address, dprintf_byte__data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= 8'h00;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (clear_overflow) begin
                r_overflow   <= 1'b0;
                r_drop_count <= 8'h00;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_load_byte  = 8'h00;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (!w_consec)                 w_state_next = c_ST_ESC_A;
                    else if (w_head_data == c_ESC) w_state_next = c_ST_ESC_D;
                    else                           w_state_next = c_ST_DATA;
                end
            end
            c_ST_ESC_A: begin
                w_load_byte = c_ESC;
                if (w_load) w_state_next = c_ST_MARK;
            end
            c_ST_MARK: begin
                w_load_byte = c_MARK;
                if (w_load) w_state_next = c_ST_ADDR_HI;
            end
            c_ST_ADDR_HI: begin
                w_load_byte = r_hold_addr[15:8];
                if (w_load) w_state_next = c_ST_ADDR_LO;
            end
            c_ST_ADDR_LO: begin
                w_load_byte = r_hold_addr[7:0];
                if (w_load) w_state_next = (r_hold_data == c_ESC) ? c_ST_ESC_D : c_ST_DATA;
            end
            c_ST_ESC_D: begin
                w_load_byte = c_ESC;
                if (w_load) w_state_next = c_ST_DATA;
            end
            c_ST_DATA: begin
                w_load_byte = r_hold_data;
                if (w_load) w_state_next = c_ST_IDLE;
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_hold_addr  <= 16'h0000;
            r_hold_data  <= 8'h00;
            r_last_addr  <= 16'h0000;
            r_last_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_pop) begin
                r_hold_addr <= w_head_addr;
                r_hold_data <= w_head_data;
            end
            if (w_load && (r_state == c_ST_DATA)) r_last_addr <= r_hold_addr;
            // A dropped byte breaks the host's address tracking, so force a header.
            if (w_drop)                                r_last_valid <= 1'b0;
            else if (w_load && (r_state == c_ST_DATA)) r_last_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_txd     <= 1'b1;
            r_sh_busy <= 1'b0;
            r_sh_data <= 9'h1FF;
            r_bit_idx <= 4'd0;
            r_clk_cnt <= 16'd0;
        end else if (w_load) begin
            r_txd     <= 1'b0;
            r_sh_busy <= 1'b1;
            r_sh_data <= {1'b1, w_load_byte};
            r_bit_idx <= 4'd0;
            r_clk_cnt <= 16'd0;
        end else if (r_sh_busy) begin
            if (w_bit_end) begin
                r_clk_cnt <= 16'd0;
                if (r_bit_idx == c_STOP_IDX) begin
                    r_sh_busy <= 1'b0;
                end else begin
                    r_txd     <= r_sh_data[0];
                    r_sh_data <= {1'b1, r_sh_data[8:1]};
                    r_bit_idx <= r_bit_idx + 4'd1;
                end
            end else begin
                r_clk_cnt <= r_clk_cnt + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dprintf_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_dprintf_uart_tx
// Function : Directed self-checking bench for dprintf_uart_tx (4 clocks/bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dprintf_uart_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [7:0]  data;
    logic [15:0] addr;
    logic        clear_ov;
    logic        txd;
    logic        busy;
    logic        overflow;
    logic [7:0]  drop_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] rx_q[$];
    int         rx_t[$];
    int         frame_err = 0;
    bit         rx_active = 0;
    int         rx_k;
    int         rx_start;
    logic [9:0] rx_bits;

    dprintf_uart_tx #(.FIFO_LOG2(4), .CLKS_PER_BIT(CPB)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .dprintf_byte__valid   (valid),
        .dprintf_byte__data    (data),
        .dprintf_byte__address (addr),
        .clear_overflow        (clear_ov),
        .txd                   (txd),
        .busy                  (busy),
        .overflow              (overflow),
        .drop_count            (drop_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // UART receiver: samples mid-bit on the falling clock edge.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                rx_active = 0;
            end else begin
                if (rx_active) rx_k++;
                else if (txd === 1'b0) begin
                    rx_active = 1;
                    rx_k      = 0;
                    rx_start  = cyc;
                end
                if (rx_active && (rx_k % CPB) == CPB / 2) begin
                    rx_bits[rx_k / CPB] = txd;
                    if (rx_k / CPB == 9) begin
                        rx_active = 0;
                        if (rx_bits[0] !== 1'b0 || rx_bits[9] !== 1'b1) frame_err++;
                        rx_q.push_back(rx_bits[8:1]);
                        rx_t.push_back(rx_start);
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [15:0] a, input logic [7:0] d);
        valid = 1'b1; addr = a; data = d;
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic wait_idle(output int idle_cyc);
        int n = 0;
        while (busy && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        idle_cyc = busy ? -1 : cyc;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic rx_clear;
        rx_q.delete();
        rx_t.delete();
    endtask

    task automatic test_reset;
        reset = 1'b1; valid = 1'b0; data = 8'h00; addr = 16'h0000; clear_ov = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (txd !== 1'b1)        begin n_fail++; $display("FAIL reset_txd: got %b expected 1", txd); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (overflow !== 1'b0)   begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_checks++; if (drop_count !== 8'h0) begin n_fail++; $display("FAIL reset_drop_count: got %h expected 00", drop_count); end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_single;
        int t0, idle_cyc;
        logic [7:0] exp[$];
        exp = '{8'h1B, 8'h40, 8'h10, 8'h10, 8'h41};
        rx_clear();
        valid = 1'b1; addr = 16'h1010; data = 8'h41;
        @(posedge clk); #1;
        valid = 1'b0;
        t0 = cyc;
        @(posedge clk); #1;
        n_checks++; if (txd !== 1'b1)  begin n_fail++; $display("FAIL single_txd_c1: got %b expected 1", txd); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_c1: got %b expected 1", busy); end
        @(posedge clk); #1;
        n_checks++; if (txd !== 1'b0)  begin n_fail++; $display("FAIL single_start_c2: got %b expected 0", txd); end
        wait_idle(idle_cyc);
        n_checks++; if (idle_cyc != t0 + 202) begin n_fail++; $display("FAIL single_busy_fall: got %0d expected %0d", idle_cyc - t0, 202); end
        n_checks++; if (rx_q.size() != exp.size()) begin n_fail++; $display("FAIL single_count: got %0d expected %0d", rx_q.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== exp[i]) begin n_fail++; $display("FAIL single_byte%0d: got %h expected %h", i, rx_q[i], exp[i]); end
        end
        if (rx_t.size() > 0) begin
            n_checks++; if (rx_t[0] != t0 + 2) begin n_fail++; $display("FAIL single_frame_start: got %0d expected %0d", rx_t[0] - t0, 2); end
        end
    endtask

    task automatic test_consecutive;
        int idle_cyc;
        logic [7:0] exp[$];
        exp = '{8'h1B, 8'h40, 8'h20, 8'h10, 8'h31, 8'h32, 8'h33, 8'h1B, 8'h40, 8'h20, 8'h20, 8'h34};
        rx_clear();
        valid = 1'b1; addr = 16'h2010; data = 8'h31;
        @(posedge clk); #1; addr = 16'h2011; data = 8'h32;
        @(posedge clk); #1; addr = 16'h2012; data = 8'h33;
        @(posedge clk); #1; valid = 1'b0;
        wait_idle(idle_cyc);
        n_checks++; if (idle_cyc < 0) begin n_fail++; $display("FAIL consec_idle: got timeout expected idle"); end
        send_byte(16'h2020, 8'h34);
        wait_idle(idle_cyc);
        n_checks++; if (rx_q.size() != exp.size()) begin n_fail++; $display("FAIL consec_count: got %0d expected %0d", rx_q.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== exp[i]) begin n_fail++; $display("FAIL consec_byte%0d: got %h expected %h", i, rx_q[i], exp[i]); end
        end
        for (int k = 1; k < 7 && k < rx_t.size(); k++) begin
            n_checks++; if (rx_t[k] - rx_t[0] != 10 * CPB * k) begin n_fail++; $display("FAIL consec_gap%0d: got %0d expected %0d", k, rx_t[k] - rx_t[0], 10 * CPB * k); end
        end
    endtask

    task automatic test_escape;
        int idle_cyc;
        logic [7:0] exp[$];
        exp = '{8'h1B, 8'h1B, 8'h1B, 8'h40, 8'h1B, 8'h1B, 8'h42};
        send_byte(16'h3010, 8'h55);
        wait_idle(idle_cyc);
        rx_clear();
        send_byte(16'h3011, 8'h1B);
        wait_idle(idle_cyc);
        send_byte(16'h1B1B, 8'h42);
        wait_idle(idle_cyc);
        n_checks++; if (rx_q.size() != exp.size()) begin n_fail++; $display("FAIL escape_count: got %0d expected %0d", rx_q.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== exp[i]) begin n_fail++; $display("FAIL escape_byte%0d: got %h expected %h", i, rx_q[i], exp[i]); end
        end
    endtask

    task automatic test_wrap;
        int idle_cyc;
        logic [7:0] exp[$];
        exp = '{8'h1B, 8'h40, 8'hFF, 8'hFF, 8'h61, 8'h62};
        rx_clear();
        valid = 1'b1; addr = 16'hFFFF; data = 8'h61;
        @(posedge clk); #1; addr = 16'h0000; data = 8'h62;
        @(posedge clk); #1; valid = 1'b0;
        wait_idle(idle_cyc);
        n_checks++; if (rx_q.size() != exp.size()) begin n_fail++; $display("FAIL wrap_count: got %0d expected %0d", rx_q.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== exp[i]) begin n_fail++; $display("FAIL wrap_byte%0d: got %h expected %h", i, rx_q[i], exp[i]); end
        end
    endtask

    task automatic test_overflow;
        int idle_cyc;
        logic [7:0] exp[$];
        exp = '{8'h1B, 8'h40, 8'h40, 8'h00, 8'h60};
        for (int i = 1; i <= 16; i++) exp.push_back(8'(8'h60 + i));
        exp.push_back(8'h1B); exp.push_back(8'h40); exp.push_back(8'h50);
        exp.push_back(8'h00); exp.push_back(8'h7A);
        rx_clear();
        for (int i = 0; i < 20; i++) begin
            valid = 1'b1; addr = 16'(16'h4000 + i); data = 8'(8'h60 + i);
            @(posedge clk); #1;
        end
        n_checks++; if (overflow !== 1'b1)    begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        n_checks++; if (drop_count !== 8'd3)  begin n_fail++; $display("FAIL ovf_drops: got %0d expected 3", drop_count); end
        clear_ov = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin n_fail++; $display("FAIL ovf_clear_prio: got %b/%0d expected 0/0", overflow, drop_count); end
        clear_ov = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (overflow !== 1'b1 || drop_count !== 8'd1) begin n_fail++; $display("FAIL ovf_redrop: got %b/%0d expected 1/1", overflow, drop_count); end
        valid = 1'b0; clear_ov = 1'b1;
        @(posedge clk); #1;
        clear_ov = 1'b0;
        n_checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin n_fail++; $display("FAIL ovf_clear: got %b/%0d expected 0/0", overflow, drop_count); end
        wait_idle(idle_cyc);
        send_byte(16'h5000, 8'h7A);
        wait_idle(idle_cyc);
        n_checks++; if (rx_q.size() != exp.size()) begin n_fail++; $display("FAIL ovf_count: got %0d expected %0d", rx_q.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== exp[i]) begin n_fail++; $display("FAIL ovf_byte%0d: got %h expected %h", i, rx_q[i], exp[i]); end
        end
    endtask

    task automatic test_reset_mid;
        int t0, idle_cyc;
        logic [7:0] exp[$];
        exp = '{8'h1B, 8'h40, 8'h10, 8'h11, 8'h44};
        valid = 1'b1; addr = 16'h1010; data = 8'h45;
        @(posedge clk); #1;
        valid = 1'b0;
        t0 = cyc;
        repeat (15) @(posedge clk);
        #1;
        n_checks++; if (txd !== 1'b0) begin n_fail++; $display("FAIL midrst_databit: got %b expected 0", txd); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (txd !== 1'b1)  begin n_fail++; $display("FAIL midrst_txd: got %b expected 1", txd); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        rx_clear();
        send_byte(16'h1011, 8'h44);
        wait_idle(idle_cyc);
        n_checks++; if (rx_q.size() != exp.size()) begin n_fail++; $display("FAIL midrst_count: got %0d expected %0d", rx_q.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== exp[i]) begin n_fail++; $display("FAIL midrst_byte%0d: got %h expected %h", i, rx_q[i], exp[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_consecutive();
        test_escape();
        test_wrap();
        test_overflow();
        test_reset_mid();
        n_checks++; if (frame_err != 0) begin n_fail++; $display("FAIL framing: got %0d bad frames expected 0", frame_err); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
